// File: rtl/count_seq_checker_pkg.sv
// Shared types and defaults for the count sequence checker.
package count_pkg;

    localparam int COUNT_W    = 4;
    localparam int LOCK_N_DEF = 4;
    localparam int STAT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Increment v unless it already sits at max.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/count_seq_checker_if.sv
// Observation/control bus between a count source and its checker.
interface count_seq_checker_if #(
    parameter int WIDTH  = 4,
    parameter int STAT_W = 8
) ();
    logic              en;
    logic [WIDTH-1:0]  cnt_in;
    logic              clr_stats;
    logic              locked;
    logic              err;
    logic [STAT_W-1:0] err_cnt;
    logic [STAT_W-1:0] wrap_cnt;
    logic [WIDTH-1:0]  exp_out;

    modport master (
        output en, cnt_in, clr_stats,
        input  locked, err, err_cnt, wrap_cnt, exp_out
    );

    modport slave (
        input  en, cnt_in, clr_stats,
        output locked, err, err_cnt, wrap_cnt, exp_out
    );
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating statistics counter; clear wins over increment.
module sat_counter
    import count_pkg::*;
#(
    parameter int STAT_W = STAT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [STAT_W-1:0] cnt
);
    localparam logic [STAT_W-1:0] MAX = {STAT_W{1'b1}};

    // Count register: async reset, sync clear with priority, saturating increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= STAT_W'(sat_inc(32'(cnt), 32'(MAX)));
    end
endmodule

// File: rtl/count_seq_checker.sv
// Passive monitor checking that an observed count advances by one each sample.
//
// state  | meaning
// IDLE   | disabled or just reset; next enabled sample seeds exp
// HUNT   | counting consecutive correct increments toward lock
// LOCKED | sequence trusted; any break is reported as an error
module count_seq_checker
    import count_pkg::*;
#(
    parameter int WIDTH  = COUNT_W,
    parameter int LOCK_N = LOCK_N_DEF,
    parameter int STAT_W = STAT_W_DEF
) (
    input logic           clk,
    input logic           reset,
    count_seq_checker_if.slave bus
);
    state_t           state, state_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic [7:0]       run_q, run_n;
    logic             locked_q, locked_n;
    logic             err_q, err_n;
    logic             err_inc, wrap_inc;
    logic             match;

    assign match = (bus.cnt_in == exp_q);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            exp_q    <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            exp_q    <= exp_n;
            run_q    <= run_n;
            locked_q <= locked_n;
            err_q    <= err_n;
        end
    end

    // Next-state, expected value, run length and statistic strobes.
    always_comb begin
        state_n  = state;
        exp_n    = exp_q;
        run_n    = run_q;
        locked_n = locked_q;
        err_n    = 1'b0;
        err_inc  = 1'b0;
        wrap_inc = 1'b0;
        if (!bus.en) begin
            state_n  = IDLE;
            locked_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    exp_n    = bus.cnt_in + WIDTH'(1);
                    run_n    = '0;
                    locked_n = 1'b0;
                    state_n  = HUNT;
                end
                HUNT: begin
                    if (match) begin
                        exp_n = exp_q + WIDTH'(1);
                        run_n = run_q + 8'd1;
                        if (run_q + 8'd1 == 8'(LOCK_N)) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                        end
                    end else begin
                        run_n = '0;
                        exp_n = bus.cnt_in + WIDTH'(1);
                    end
                end
                LOCKED: begin
                    if (match) begin
                        exp_n    = exp_q + WIDTH'(1);
                        wrap_inc = (bus.cnt_in == '0);
                    end else begin
                        err_n    = 1'b1;
                        err_inc  = 1'b1;
                        locked_n = 1'b0;
                        run_n    = '0;
                        exp_n    = bus.cnt_in + WIDTH'(1);
                        state_n  = HUNT;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (bus.clr_stats),
        .cnt   (bus.err_cnt)
    );

    sat_counter #(.STAT_W(STAT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc),
        .clr   (bus.clr_stats),
        .cnt   (bus.wrap_cnt)
    );

    assign bus.locked  = locked_q;
    assign bus.err     = err_q;
    assign bus.exp_out = exp_q;
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receiving end of the free-running counter output bus: samples a WIDTH-bit count stream every clock and checks that it increments by 1 modulo 2^WIDTH.
- Locks after LOCK_N consecutive correct increments. Flags each break in sequence while locked, and keeps saturating error and wrap statistics.
- Sits beside any counter instance, in simulation or on board, as a self-checking monitor. It has no effect on the counter.

Parameters:
- WIDTH, 4, width of the observed count bus.
- LOCK_N, 4, consecutive correct increments needed to enter LOCKED (range 1..255).
- STAT_W, 8, width of err_cnt and wrap_cnt (saturating).

Ports:
- clk  input  1  system clock; everything samples on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  check enable; cnt_in is sampled only while en=1.
- cnt_in  input  WIDTH  observed count value.
- clr_stats  input  1  synchronous clear of err_cnt and wrap_cnt.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse on a sequence break detected in LOCKED.
- err_cnt  output  STAT_W  number of errors, saturating.
- wrap_cnt  output  STAT_W  number of matched wraps (max to 0) while LOCKED, saturating.
- exp_out  output  WIDTH  value expected on the next sample.

Behaviour:
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE
  - locked=0, err=0, err_cnt=0, wrap_cnt=0, exp_out=0, run=0
- All outputs are registered. A sample taken at edge k is reflected on the outputs after edge k.
- State IDLE, en=1:
  - exp<=cnt_in+1 (mod 2^WIDTH), run<=0, go to HUNT.
  - err is never raised in IDLE.
- State HUNT, en=1:
  - Match (cnt_in==exp): exp<=exp+1. If run+1==LOCK_N, go to LOCKED and set locked<=1; otherwise run<=run+1.
  - Mismatch: run<=0, exp<=cnt_in+1, no err, no err_cnt change (resynchronise silently).
- State LOCKED, en=1:
  - Match: exp<=exp+1. If cnt_in==0, wrap_cnt increments (saturating).
  - Mismatch:
    - err<=1 for exactly one cycle; err_cnt increments (saturating at 2^STAT_W-1).
    - locked<=0, run<=0, exp<=cnt_in+1, go to HUNT.
- en=0 in any state: next state IDLE, locked<=0, err<=0. err_cnt, wrap_cnt and exp_out hold.
- clr_stats=1: err_cnt<=0 and wrap_cnt<=0, taking priority over a simultaneous increment. The err pulse itself is still produced.
- The checker does not know about counter resets. A counter reset seen while LOCKED (e.g. 7 then 0) is reported as an error.
- LOCK_N=1: the first correct increment after IDLE enters LOCKED.
- Arithmetic: exp wraps modulo 2^WIDTH. run is 8 bits. Both statistics saturate and never wrap.
- State encoding: IDLE=0, HUNT=1, LOCKED=2. The unused encoding recovers to IDLE.

Decomposition:
- Shared package count_pkg holds:
  - the state enum (IDLE, HUNT, LOCKED)
  - default constants COUNT_W=4, LOCK_N_DEF=4, STAT_W_DEF=8
  - a sat_inc helper function
- One natural sub-module: sat_counter (STAT_W-bit saturating counter with inc and sync clr, clr priority). It is instantiated twice, for err_cnt and wrap_cnt.
- FSM and exp/run datapath stay in the top module.

Test Plan (WIDTH=4, LOCK_N=4, STAT_W=8):
- Lock: reset, then en=1 with cnt_in 0,1,2,3,4 -> locked rises after the edge sampling 4, exp_out=5, err never asserted.
- Wrap: locked, feed 14,15,0,1 -> no err, wrap_cnt=1, exp_out=2 afterwards.
- Break and relock:
  - Locked expecting 6, feed 9 -> err high exactly one cycle, err_cnt=1, locked=0, exp_out=10.
  - Then feed 10,11,12,13 -> locked=1 again.
  - Separately, a jump of 7 then 0 while locked also gives err=1.
- HUNT noise and en drop:
  - Unlocked, feed 3,8,2,9 -> no err, err_cnt unchanged.
  - While locked, drop en for 2 cycles -> locked=0, state IDLE, stats hold. Re-enable and feed 4 consecutive increments -> relock.
- Async reset mid-stream: assert reset between clock edges while locked with err_cnt=3 -> all outputs 0 immediately, without waiting for a clock edge.
- Saturation and clear:
  - Force 300 locked-state errors -> err_cnt=255 and it stays there.
  - Assert clr_stats in the same cycle as a mismatch -> err pulses, err_cnt=0.
